// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32 control unit: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath controls.
// Optional feature macro: ILLEGAL_TRAP_EN (unsupported instructions park the FSM in TRAP until reset).
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_FETCH  | latch instruction word into IR
// S_DECODE | classify IR by opcode
// S_EXEC   | drive ALU op/operand select; branches resolve and retire here
// S_MEM    | data RAM access; stores retire here
// S_WB     | register file write-back; R/I/LOAD retire here
// S_TRAP   | illegal instruction seen, wait for reset (ILLEGAL_TRAP_EN only)
module multicycle_ctrl_fsm #(
  parameter int INST_W  = 32,
  parameter int ALUOP_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INST_W-1:0]  inst,
  input  logic [3:0]         status,
  output logic               RegWrite,
  output logic               PCSrc,
  output logic               ALUSrc,
  output logic [ALUOP_W-1:0] ALU_operation,
  output logic               write,
  output logic               MemtoReg,
  output logic               pc_en,
  output logic [CNT_W-1:0]   instret,
  output logic               illegal
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  localparam logic [ALUOP_W-1:0] OP_ADD  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] OP_SUB  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] OP_AND  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] OP_OR   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] OP_XOR  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] OP_SLL  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] OP_SRL  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] OP_SRA  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] OP_SLT  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] OP_SLTU = ALUOP_W'(9);

  localparam logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013);

  state_t              state, state_nxt;
  logic [INST_W-1:0]   ir;
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic                funct7_b5;
  logic                is_r, is_i, is_ld, is_st, is_br, legal;
  logic                zero_flag;
  logic [ALUOP_W-1:0]  alu_op_dec;
  logic                alu_src_dec;
  logic                unused_bits;

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign funct7_b5 = ir[30];
  assign zero_flag = status[0];

  assign is_r  = (opcode == 7'b0110011);
  assign is_i  = (opcode == 7'b0010011);
  assign is_ld = (opcode == 7'b0000011);
  assign is_st = (opcode == 7'b0100011);
  assign is_br = (opcode == 7'b1100011) && (funct3[2:1] == 2'b00);
  assign legal = is_r | is_i | is_ld | is_st | is_br;

  assign unused_bits = ^{ir[INST_W-1:31], ir[29:15], ir[11:7], status[3:1]};

  // funct7[5] means SUB only for register ops; for immediates it is just an imm bit except SRAI.
  always_comb begin
    alu_op_dec  = OP_ADD;
    alu_src_dec = is_i | is_ld | is_st;
    if (is_r || is_i) begin
      case (funct3)
        3'b000:  alu_op_dec = (is_r && funct7_b5) ? OP_SUB : OP_ADD;
        3'b001:  alu_op_dec = OP_SLL;
        3'b010:  alu_op_dec = OP_SLT;
        3'b011:  alu_op_dec = OP_SLTU;
        3'b100:  alu_op_dec = OP_XOR;
        3'b101:  alu_op_dec = funct7_b5 ? OP_SRA : OP_SRL;
        3'b110:  alu_op_dec = OP_OR;
        default: alu_op_dec = OP_AND;
      endcase
    end else if (is_br) begin
      alu_op_dec = OP_SUB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      ir      <= NOP_INST;
      instret <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH) ir <= inst;
      if (pc_en) instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt     = state;
    RegWrite      = 1'b0;
    PCSrc         = 1'b0;
    ALUSrc        = 1'b0;
    ALU_operation = OP_ADD;
    write         = 1'b0;
    MemtoReg      = 1'b0;
    pc_en         = 1'b0;
    illegal       = 1'b0;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        state_nxt = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
        if (!legal) state_nxt = S_TRAP;
`endif
      end
      S_EXEC: begin
        ALU_operation = alu_op_dec;
        ALUSrc        = alu_src_dec;
        if (is_r || is_i) begin
          state_nxt = S_WB;
        end else if (is_ld || is_st) begin
          state_nxt = S_MEM;
        end else begin
          // Branches retire here; anything else that reaches EXEC retires as a NOP.
          PCSrc     = is_br && (funct3[0] ? !zero_flag : zero_flag);
          pc_en     = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_MEM: begin
        ALU_operation = alu_op_dec;
        ALUSrc        = alu_src_dec;
        if (is_st) begin
          write     = 1'b1;
          pc_en     = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        ALU_operation = alu_op_dec;
        ALUSrc        = alu_src_dec;
        RegWrite      = 1'b1;
        MemtoReg      = is_ld;
        pc_en         = 1'b1;
        state_nxt     = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: illegal = 1'b1;
`endif
      default: state_nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm; expected values are hand-derived from instruction encodings.
// Honours ILLEGAL_TRAP_EN the same way the design does for the illegal-opcode case.
module tb_multicycle_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst;
  logic [3:0]  status;
  logic        RegWrite, PCSrc, ALUSrc, write, MemtoReg, pc_en, illegal;
  logic [4:0]  ALU_operation;
  logic [15:0] instret;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_instret = '0;

  multicycle_ctrl_fsm #(.INST_W(32), .ALUOP_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .inst(inst), .status(status),
    .RegWrite(RegWrite), .PCSrc(PCSrc), .ALUSrc(ALUSrc), .ALU_operation(ALU_operation),
    .write(write), .MemtoReg(MemtoReg), .pc_en(pc_en), .instret(instret), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Outputs are sampled on the falling edge, half a cycle after the state register moves.
  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] r_enc(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_enc(input logic [11:0] imm, input logic [2:0] f3);
    return {imm, 5'd1, f3, 5'd3, 7'b0010011};
  endfunction

  // Caller leaves the FSM in FETCH; drives an R/I instruction through all four cycles.
  task automatic run_alu(input string tag, input logic [31:0] ins, input logic [4:0] op,
                         input logic src);
    inst = ins;
    tick();
    chk({tag, " decode pc_en"}, 32'(pc_en), 0);
    tick();
    chk({tag, " exec op"}, 32'(ALU_operation), 32'(op));
    chk({tag, " exec alusrc"}, 32'(ALUSrc), 32'(src));
    chk({tag, " exec pc_en"}, 32'(pc_en), 0);
    tick();
    chk({tag, " wb regwrite/pc_en/memtoreg"}, {29'd0, RegWrite, pc_en, MemtoReg}, 32'b110);
    exp_instret++;
    tick();
    chk({tag, " instret"}, 32'(instret), 32'(exp_instret));
  endtask

  initial begin
    reset  = 1'b1;
    inst   = 32'h0;
    status = 4'h0;
    tick();
    tick();
    chk("reset ctrl", {24'd0, RegWrite, PCSrc, ALUSrc, write, MemtoReg, pc_en, illegal, 1'b0}, 0);
    chk("reset aluop", 32'(ALU_operation), 0);
    chk("reset instret", 32'(instret), 0);
    reset = 1'b0;

    // add x3,x1,x2
    inst = 32'h002081B3;
    chk("add fetch pc_en", 32'(pc_en), 0);
    tick();
    chk("add decode ctrl", {29'd0, RegWrite, write, pc_en}, 0);
    tick();
    chk("add exec op", 32'(ALU_operation), 0);
    chk("add exec alusrc", 32'(ALUSrc), 0);
    chk("add exec regwrite", 32'(RegWrite), 0);
    tick();
    chk("add wb regwrite/memtoreg/pc_en", {29'd0, RegWrite, MemtoReg, pc_en}, 32'b101);
    exp_instret++;
    tick();
    chk("add instret", 32'(instret), 32'(exp_instret));
    chk("add fetch regwrite", 32'(RegWrite), 0);

    // lw x3,0(x1)
    inst = 32'h0000A183;
    tick();
    tick();
    chk("lw exec alusrc/op", {26'd0, ALUSrc, ALU_operation}, {26'd0, 1'b1, 5'd0});
    chk("lw exec write/pc_en", {30'd0, write, pc_en}, 0);
    tick();
    chk("lw mem alusrc/op", {26'd0, ALUSrc, ALU_operation}, {26'd0, 1'b1, 5'd0});
    chk("lw mem write/regwrite/pc_en", {29'd0, write, RegWrite, pc_en}, 0);
    tick();
    chk("lw wb memtoreg/regwrite/pc_en/write", {28'd0, MemtoReg, RegWrite, pc_en, write}, 32'b1110);
    exp_instret++;
    tick();
    chk("lw instret", 32'(instret), 32'(exp_instret));

    // sw x2,0(x1)
    inst = 32'h0020A023;
    tick();
    tick();
    chk("sw exec write/regwrite/alusrc", {29'd0, write, RegWrite, ALUSrc}, 32'b001);
    tick();
    chk("sw mem write/pc_en/regwrite", {29'd0, write, pc_en, RegWrite}, 32'b110);
    exp_instret++;
    tick();
    chk("sw fetch write/regwrite", {30'd0, write, RegWrite}, 0);
    chk("sw instret", 32'(instret), 32'(exp_instret));

    // beq taken, beq not taken, bne taken
    inst = 32'h00208463;
    status = 4'b0001;
    tick();
    tick();
    chk("beq taken exec pcsrc/pc_en", {30'd0, PCSrc, pc_en}, 32'b11);
    chk("beq taken exec op/alusrc", {26'd0, ALUSrc, ALU_operation}, 32'd1);
    exp_instret++;
    tick();
    chk("beq taken fetch pcsrc", 32'(PCSrc), 0);
    chk("beq taken instret", 32'(instret), 32'(exp_instret));
    status = 4'b0000;
    tick();
    tick();
    chk("beq not taken pcsrc/pc_en", {30'd0, PCSrc, pc_en}, 32'b01);
    chk("beq not taken op", 32'(ALU_operation), 1);
    exp_instret++;
    tick();
    inst = 32'h00209463;
    status = 4'b1110;
    tick();
    tick();
    chk("bne taken pcsrc/pc_en", {30'd0, PCSrc, pc_en}, 32'b11);
    exp_instret++;
    tick();
    chk("branches instret", 32'(instret), 32'(exp_instret));
    status = 4'b0000;

    // ALU op decode across funct3/funct7 combinations
    run_alu("sub",   r_enc(7'b0100000, 3'b000), 5'd1, 1'b0);
    run_alu("sll",   r_enc(7'b0000000, 3'b001), 5'd5, 1'b0);
    run_alu("slt",   r_enc(7'b0000000, 3'b010), 5'd8, 1'b0);
    run_alu("sltu",  r_enc(7'b0000000, 3'b011), 5'd9, 1'b0);
    run_alu("xor",   r_enc(7'b0000000, 3'b100), 5'd4, 1'b0);
    run_alu("srl",   r_enc(7'b0000000, 3'b101), 5'd6, 1'b0);
    run_alu("sra",   r_enc(7'b0100000, 3'b101), 5'd7, 1'b0);
    run_alu("or",    r_enc(7'b0000000, 3'b110), 5'd3, 1'b0);
    run_alu("and",   r_enc(7'b0000000, 3'b111), 5'd2, 1'b0);
    run_alu("addi b30", i_enc(12'h400, 3'b000), 5'd0, 1'b1);
    run_alu("srai",  i_enc(12'h401, 3'b101), 5'd7, 1'b1);
    run_alu("srli",  i_enc(12'h001, 3'b101), 5'd6, 1'b1);
    run_alu("andi",  i_enc(12'h0FF, 3'b111), 5'd2, 1'b1);

    // reset during the MEM cycle of a store aborts it
    inst = 32'h0020A023;
    tick();
    tick();
    tick();
    chk("abort sw mem write", 32'(write), 1);
    reset = 1'b1;
    tick();
    chk("abort write/pc_en/regwrite", {29'd0, write, pc_en, RegWrite}, 0);
    chk("abort instret", 32'(instret), 0);
    exp_instret = '0;
    reset = 1'b0;
    run_alu("post-abort add", 32'h002081B3, 5'd0, 1'b0);

    // unsupported opcode
    inst = 32'hFFFFFFFF;
    tick();
    tick();
`ifdef ILLEGAL_TRAP_EN
    chk("trap illegal", 32'(illegal), 1);
    chk("trap pc_en/write/regwrite", {29'd0, pc_en, write, RegWrite}, 0);
    inst = 32'h002081B3;
    repeat (5) tick();
    chk("trap held", 32'(illegal), 1);
    chk("trap instret", 32'(instret), 32'(exp_instret));
    reset = 1'b1;
    tick();
    chk("trap cleared", 32'(illegal), 0);
    exp_instret = '0;
    reset = 1'b0;
    run_alu("post-trap add", 32'h002081B3, 5'd0, 1'b0);
`else
    chk("nop pc_en", 32'(pc_en), 1);
    chk("nop ctrl", {27'd0, illegal, write, RegWrite, PCSrc, ALUSrc}, 0);
    exp_instret++;
    tick();
    chk("nop instret", 32'(instret), 32'(exp_instret));
    // BRANCH with an unsupported funct3 (blt) also runs as a NOP
    inst = 32'h0020C463;
    status = 4'b0001;
    tick();
    tick();
    chk("blt nop pcsrc/pc_en", {30'd0, PCSrc, pc_en}, 32'b01);
    exp_instret++;
    tick();
    chk("blt nop instret", 32'(instret), 32'(exp_instret));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
